// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the default lock timeout (100 ms at 27 MHz).
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_GAP   = 2'b10
    } arb_state_e;

    localparam int UART_BYTE_W          = 8;
    localparam int DEFAULT_LOCK_TIMEOUT = 2700000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request found
// above the pointer, wrapping back to index 0.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic             o_found
);

    // Two constant-index passes (above the pointer, then at/below it) express
    // the modulo wrap without a variable rotate.
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_found && i_req[i] && (i > int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                o_found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!o_found && i_req[i] && (i <= int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                o_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between byte sources
// (requester 0: SPI echo path, requester 1: periodic string sender).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_last,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ack,
    input  logic                           i_uart_fifo_ready,
    output logic                           o_start_uart,
    output logic [UART_BYTE_W-1:0]         o_uart_tx_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy,
    output logic                           o_lock_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_e             r_state, w_state_nxt;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]     r_ack, w_ack_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_start, w_start_nxt;
    logic                   r_tmo, w_tmo_nxt;
    logic                   r_last, w_last_nxt;
    logic [UART_BYTE_W-1:0] r_data, w_data_nxt;

    logic [NUM_REQ-1:0]     w_pick;
    logic                   w_found;
    logic                   w_own_valid;
    logic                   w_own_last;
    logic [UART_BYTE_W-1:0] w_own_data;
    logic [PTR_W-1:0]       w_own_idx;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_found (w_found)
    );

    // The one-hot grant selects the owner's valid, last flag and byte.
    always_comb begin
        w_own_valid = |(i_req_valid & r_grant);
        w_own_last  = |(i_req_last & r_grant);
        w_own_data  = '0;
        w_own_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_own_data = w_own_data | i_req_data[i*UART_BYTE_W +: UART_BYTE_W];
                w_own_idx  = PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        w_data_nxt  = r_data;
        w_start_nxt = 1'b0;
        w_ack_nxt   = '0;
        w_tmo_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_uart_fifo_ready && w_found) begin
                    w_grant_nxt = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A ready-stall with valid high holds the counter; only a silent owner ages the lock.
                if (w_own_valid && i_uart_fifo_ready) begin
                    w_data_nxt  = w_own_data;
                    w_start_nxt = 1'b1;
                    w_ack_nxt   = r_grant;
                    w_last_nxt  = w_own_last;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo_nxt   = 1'b1;
                    w_ptr_nxt   = w_own_idx;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (!w_own_valid && (r_cnt < CNT_LAST)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_last) begin
                    w_ptr_nxt   = w_own_idx;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= PTR_W'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_tmo   <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_start <= w_start_nxt;
            r_tmo   <= w_tmo_nxt;
            r_last  <= w_last_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign o_req_ack      = r_ack;
    assign o_start_uart   = r_start;
    assign o_uart_tx_data = r_data;
    assign o_grant        = r_grant;
    assign o_busy         = r_busy;
    assign o_lock_timeout = r_tmo;

endmodule
